alu_step_sequencer: RTL and testbench
=====================================

# alu_step_sequencer

- Parametrised control-step generator for the datapath.
- Replaces the hand-driven T0–T5 control sequences with a clocked Moore state machine.
- Runs fetch plus register-register ALU execution for any opcode in the decided set, including two-word MUL/DIV writeback to HI/LO.
- Adds a memory-ready handshake, an ALU-busy stall, a fault state and a retired-instruction counter.

## Interface

Parameters:
- NREG, 16, number of general registers; width of the one-hot Rin/Rout buses.
- RSEL_W, 4, register-field width in IR; must satisfy 2**RSEL_W >= NREG.
- MEM_TIMEOUT, 8, maximum cycles in T1 without mem_ready before FAULT.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  sole clock, rising edge.
- Clear  in  1  asynchronous, active-high reset.
- Run  in  1  level; while high, instructions execute back-to-back.
- ir  in  32  datapath IR contents.
- mem_ready  in  1  memory read data valid on Mdatain.
- alu_busy  in  1  multicycle ALU (MUL/DIV) still computing.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  ALU PC-increment mode; memory read strobe.
- alu_op  out  5  opcode presented to the ALU; 0 when idle.
- Rin, Rout  out  NREG each  one-hot register load / drive selects.
- Done  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  sticky fault flag.
- retired  out  CNT_W  retired-instruction count; wraps to 0.

## Operation

IR fields:
- opcode = ir[31:27]
- Ra = ir[26:23]
- Rb = ir[22:19]
- Rc = ir[18:15]

Decided opcode set:
- Binary ops: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010.
- Two-word ops: MUL 01111, DIV 10000.
- Unary ops: NEG 10001, NOT 10010.
- Every other opcode is illegal.

States and outputs:
- IDLE: all outputs 0. Go to T0 when Run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0. PCin is asserted only in the exit cycle, so PC loads once.
  - Wait counter exceeds MEM_TIMEOUT: go to FAULT.
- T2: MDRout, IRin.
- T3: sequencer latches opcode/Ra/Rb/Rc from ir.
  - Illegal opcode, or any used field >= NREG: go to FAULT with no enables.
  - Binary or MUL/DIV: Rout[Rb], Yin.
  - Unary: no enables; one cycle only.
- T4: alu_op=opcode, Zin.
  - Binary, MUL, DIV: Rout[Rc].
  - Unary: Rout[Rb].
  - Holds while alu_busy=1.
- T5: Zlowout.
  - MUL/DIV: LOin, then go to T6.
  - Otherwise: Rin[Ra], Done, then go to T0 if Run else IDLE.
- T6 (MUL/DIV only): Zhighout, HIin, Done, then go to T0 if Run else IDLE.
- FAULT: Illegal=1, all other enables 0. Left only by Clear.

Other rules:
- All outputs are Moore, decoded from the state register and latched fields only.
- Rin and Rout are one-hot or all-zero; never multi-hot.
- retired increments on each Done and wraps from 2**CNT_W-1 to 0.
- Run falling mid-instruction has no effect; the instruction completes, then the machine goes to IDLE.

## Timing

- Clear asserted: all outputs 0 within the same cycle, state IDLE, retired 0, Illegal 0, wait counter 0. Applies at any point, including mid-instruction.
- Minimum latency, T0 entry to Done:
  - Binary: 6 cycles (mem_ready already high in T1, alu_busy low).
  - Unary: 6 cycles.
  - MUL/DIV: 7 cycles.
- Each extra low cycle of mem_ready in T1 adds 1 cycle; each extra busy cycle of alu_busy in T4 adds 1 cycle.
- The IR is loaded at the T2→T3 edge; fields are valid from T3 onward.
- mem_ready and alu_busy are sampled at the rising edge.
- T1 timeout: the first count exceeding MEM_TIMEOUT moves the machine to FAULT on that edge.
- Back-to-back execution with Run=1: T0 immediately follows the Done cycle, with no IDLE cycle between.

## Structure

- Shared package `cpu_ctrl_pkg` holds:
  - the state enumeration
  - opcode constants
  - field bit positions (RA_MSB etc.)
  - the is_binary / is_unary / is_muldiv classification functions
- Sub-module `onehot_decode` (parameter NREG): takes a field and an enable and produces the Rin/Rout one-hot vector. It is instantiated twice.

## Test plan

- AND: IR=0x4A920000, mem_ready=1, alu_busy=0 → T3 Rout[2]+Yin; T4 Rout[4], alu_op=01001; T5 Rin[5]+Done; retired=1.
- MUL: IR with opcode 01111, Rb=3, Rc=6; alu_busy high for 3 cycles of T4 → T4 lasts 4 cycles; T5 LOin; T6 HIin+Done; latency 10.
- Memory wait and timeout:
  - mem_ready low for 3 T1 cycles → exactly one PCin pulse, after which the machine proceeds.
  - mem_ready never high with MEM_TIMEOUT=8 → FAULT after 9 T1 cycles, Illegal=1.
- Illegal: opcode 11111 → FAULT at the T3 edge, no Rin/Rout ever asserted, Illegal stays high until Clear.
- Clear mid-T4 (asynchronous, between edges) → all outputs 0 immediately; after release with Run=1, T0 on the next edge; retired=0.
- Wrap and back-to-back: CNT_W=2, Run held high for 5 NOT instructions → no IDLE between instructions; retired sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-step definitions: step states, opcode encodings, IR field positions
// and opcode classification helpers.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StFault
  } step_e;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RC_MSB  = 18;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  function automatic logic is_binary(logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
  endfunction

  function automatic logic is_muldiv(logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_unary(logic [4:0] op);
    return op inside {OP_NEG, OP_NOT};
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Register-select decoder: turns a register field into a one-hot (or all-zero) select.
module onehot_decode #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NREG-1:0]  onehot_o
);

  // Out-of-range selects decode to all-zero rather than aliasing onto a real register.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot_o[i] = en_i && (32'(sel_i) == i);
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Control-step sequencer: fetch plus register-register ALU execute, with memory wait,
// ALU stall, fault trap and a retired-instruction counter.
module alu_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREG        = 16,
  parameter int unsigned RSEL_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  input  logic             alu_busy,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [4:0]       alu_op,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic             Done,
  output logic             Illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  step_e              state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [OPC_W-1:0]   opc_q;
  logic [RSEL_W-1:0]  ra_q, rb_q, rc_q;
  logic [CNT_W-1:0]   retired_q;

  logic [OPC_W-1:0]   opc;
  logic [RSEL_W-1:0]  ra, rb, rc;
  logic               ra_ok, rb_ok, rc_ok, legal;
  logic [RSEL_W-1:0]  rout_sel;
  logic               rout_en, rin_en;
  logic               unused_ir;

  assign unused_ir = ^ir[RC_MSB-RSEL_W:0];

  // The IR becomes valid only in T3, so T3 decodes it directly; later steps use the latch.
  always_comb begin
    if (state_q == StT3) begin
      opc = ir[OPC_MSB -: OPC_W];
      ra  = ir[RA_MSB -: RSEL_W];
      rb  = ir[RB_MSB -: RSEL_W];
      rc  = ir[RC_MSB -: RSEL_W];
    end else begin
      opc = opc_q;
      ra  = ra_q;
      rb  = rb_q;
      rc  = rc_q;
    end
  end

  assign ra_ok = 32'(ra) < NREG;
  assign rb_ok = 32'(rb) < NREG;
  assign rc_ok = 32'(rc) < NREG;
  assign legal = (is_binary(opc) && ra_ok && rb_ok && rc_ok) ||
                 (is_muldiv(opc) && rb_ok && rc_ok) ||
                 (is_unary(opc) && ra_ok && rb_ok);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      opc_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StT3) begin
        opc_q <= opc;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
      end
      if (Done) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign retired = retired_q;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      StIdle:  if (Run) state_d = StT0;
      StT0:    state_d = StT1;
      StT1: begin
        if (mem_ready) begin
          state_d = StT2;
        end else if (32'(wait_q) + 32'd1 > MEM_TIMEOUT) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StT2:    state_d = StT3;
      StT3:    state_d = legal ? StT4 : StFault;
      StT4:    if (!alu_busy) state_d = StT5;
      StT5:    state_d = is_muldiv(opc) ? StT6 : (Run ? StT0 : StIdle);
      StT6:    state_d = Run ? StT0 : StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    alu_op   = '0;
    Done     = 1'b0;
    Illegal  = 1'b0;
    rout_sel = '0;
    rout_en  = 1'b0;
    rin_en   = 1'b0;
    unique case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // Qualified by mem_ready so PC loads only in the exit cycle of a wait.
        PCin    = mem_ready;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (legal && !is_unary(opc)) begin
          rout_sel = rb;
          rout_en  = 1'b1;
          Yin      = 1'b1;
        end
      end
      StT4: begin
        alu_op   = opc;
        Zin      = 1'b1;
        rout_sel = is_unary(opc) ? rb : rc;
        rout_en  = 1'b1;
      end
      StT5: begin
        Zlowout = 1'b1;
        if (is_muldiv(opc)) begin
          LOin = 1'b1;
        end else begin
          rin_en = 1'b1;
          Done   = 1'b1;
        end
      end
      StT6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        Done     = 1'b1;
      end
      StFault: Illegal = 1'b1;
      default: ;
    endcase
  end

  onehot_decode #(
    .NREG (NREG),
    .SEL_W(RSEL_W)
  ) u_rout_dec (
    .sel_i   (rout_sel),
    .en_i    (rout_en),
    .onehot_o(Rout)
  );

  onehot_decode #(
    .NREG (NREG),
    .SEL_W(RSEL_W)
  ) u_rin_dec (
    .sel_i   (ra),
    .en_i    (rin_en),
    .onehot_o(Rin)
  );

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench for alu_step_sequencer: directed instructions push expected retire
// records; a negedge monitor checks each Done pulse against them.
module tb_alu_step_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int unsigned NREG  = 16;
  localparam int unsigned CNT_W = 2;

  logic             Clock = 1'b0;
  logic             Clear, Run, mem_ready, alu_busy;
  logic [31:0]      ir;
  logic             PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic             HIin, LOin, IncPC, Read, Done, Illegal;
  logic [4:0]       alu_op;
  logic [NREG-1:0]  Rin, Rout;
  logic [CNT_W-1:0] retired;
  logic [52:0]      all_out;

  always #5 Clock = ~Clock;

  alu_step_sequencer #(
    .NREG       (NREG),
    .RSEL_W     (4),
    .MEM_TIMEOUT(8),
    .CNT_W      (CNT_W)
  ) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Run      (Run),
    .ir       (ir),
    .mem_ready(mem_ready),
    .alu_busy (alu_busy),
    .PCout    (PCout),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .MDRout   (MDRout),
    .MARin    (MARin),
    .Zin      (Zin),
    .PCin     (PCin),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .Yin      (Yin),
    .HIin     (HIin),
    .LOin     (LOin),
    .IncPC    (IncPC),
    .Read     (Read),
    .alu_op   (alu_op),
    .Rin      (Rin),
    .Rout     (Rout),
    .Done     (Done),
    .Illegal  (Illegal),
    .retired  (retired)
  );

  assign all_out = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                    HIin, LOin, IncPC, Read, alu_op, Rin, Rout, Done, Illegal};

  typedef struct {
    logic [NREG-1:0]  rin;
    bit               muldiv;
    int               lat;
    logic [CNT_W-1:0] cnt_after;
  } exp_t;

  exp_t             sbq[$];
  logic [CNT_W-1:0] exp_cnt;
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               t0_cyc = 0;
  bit               chk_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_want;
  int               t4n, t1n, pcin_n;
  logic             rr_seen;
  int               t0s[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push(input logic [NREG-1:0] rin, input bit md, input int lat);
    exp_t e;
    exp_cnt     = exp_cnt + 1'b1;
    e.rin       = rin;
    e.muldiv    = md;
    e.lat       = lat;
    e.cnt_after = exp_cnt;
    sbq.push_back(e);
  endtask

  // Returns at the first negedge where T0 (PCout) is visible, bounded.
  task automatic wait_t0(input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!PCout && n < 30);
    check(name, PCout, 1);
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    exp_t e;
    if (chk_cnt) begin
      check("retired_after_done", retired, cnt_want);
      chk_cnt = 1'b0;
    end
    if (!Clear && PCout) t0_cyc = cyc;
    if (!Clear && Done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("done_rin", Rin, e.rin);
        check("done_hiin", {HIin, Zhighout}, {e.muldiv, e.muldiv});
        check("done_latency", cyc - t0_cyc + 1, e.lat);
        cnt_want = e.cnt_after;
        chk_cnt  = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clear = 1'b1; Run = 1'b0; mem_ready = 1'b1; alu_busy = 1'b0; ir = '0; exp_cnt = '0;
    repeat (2) @(negedge Clock);
    check("reset_outputs", all_out, 0);
    check("reset_retired", retired, 0);
    Clear = 1'b0;
    @(negedge Clock);
    check("idle_without_run", all_out, 0);

    // AND R5 = R2 & R4
    ir = 32'h4A920000;
    push(16'h0020, 1'b0, 6);
    Run = 1'b1;
    wait_t0("and_t0");
    check("and_t0_out", {PCout, MARin, IncPC, Zin}, 4'hf);
    Run = 1'b0;
    @(negedge Clock);
    check("and_t1_out", {Zlowout, PCin, Read, MDRin}, 4'hf);
    @(negedge Clock);
    check("and_t2_out", {MDRout, IRin}, 2'b11);
    @(negedge Clock);
    check("and_t3_rout", {Rout, Yin}, {16'h0004, 1'b1});
    @(negedge Clock);
    check("and_t4_out", {Rout, alu_op, Zin}, {16'h0010, 5'b01001, 1'b1});
    @(negedge Clock);
    check("and_t5_out", {Zlowout, Done, LOin}, 3'b110);
    @(negedge Clock);
    check("and_idle_after", all_out, 0);
    check("and_retired", retired, 1);

    // MUL Rb=3, Rc=6 with a 3-cycle ALU stall
    ir = {OP_MUL, 4'd0, 4'd3, 4'd6, 15'd0};
    push('0, 1'b1, 10);
    alu_busy = 1'b1;
    Run = 1'b1;
    wait_t0("mul_t0");
    Run = 1'b0;
    repeat (3) @(negedge Clock);
    check("mul_t3_rout", {Rout, Yin}, {16'h0008, 1'b1});
    t4n = 0;
    @(negedge Clock);
    while (Zin && alu_op == OP_MUL && t4n < 20) begin
      t4n++;
      check("mul_t4_rout", Rout, 16'h0040);
      if (t4n == 4) alu_busy = 1'b0;
      @(negedge Clock);
    end
    check("mul_t4_cycles", t4n, 4);
    check("mul_t5_out", {Zlowout, LOin, Done, Rin}, {3'b110, 16'h0000});
    @(negedge Clock);
    check("mul_t6_out", {Zhighout, HIin, Done}, 3'b111);
    repeat (2) @(negedge Clock);

    // ADD with three memory-wait cycles in T1
    ir = {OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0};
    push(16'h0002, 1'b0, 9);
    mem_ready = 1'b0;
    Run = 1'b1;
    wait_t0("wait_t0");
    Run = 1'b0;
    pcin_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("wait_t1_read", Read, 1);
      pcin_n += int'(PCin);
    end
    @(posedge Clock);
    #1 mem_ready = 1'b1;
    @(negedge Clock);
    check("wait_t1_exit_pcin", {Read, PCin}, 2'b11);
    pcin_n += int'(PCin);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      pcin_n += int'(PCin);
    end
    check("wait_pcin_pulses", pcin_n, 1);

    // Asynchronous Clear in the middle of a stalled T4
    ir = {OP_SUB, 4'd7, 4'd8, 4'd9, 15'd0};
    alu_busy = 1'b1;
    Run = 1'b1;
    wait_t0("clr_t0");
    repeat (4) @(negedge Clock);
    check("clr_in_t4", {Zin, alu_op}, {1'b1, OP_SUB});
    #2 Clear = 1'b1;
    #1;
    check("clr_outputs_now", all_out, 0);
    check("clr_retired_now", retired, 0);
    exp_cnt = '0;
    alu_busy = 1'b0;
    @(negedge Clock);
    Clear = 1'b0;
    push(16'h0080, 1'b0, 6);
    @(posedge Clock);
    #1;
    check("clr_t0_next_edge", PCout, 1);
    Run = 1'b0;
    repeat (8) @(negedge Clock);

    // T1 timeout: mem_ready never arrives
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    exp_cnt = '0;
    ir = {OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0};
    mem_ready = 1'b0;
    Run = 1'b1;
    wait_t0("tmo_t0");
    Run = 1'b0;
    t1n = 0;
    @(negedge Clock);
    while (Read && t1n < 20) begin
      t1n++;
      @(negedge Clock);
    end
    check("tmo_t1_cycles", t1n, 9);
    check("tmo_fault_out", all_out, 1);
    repeat (3) @(negedge Clock);
    check("tmo_fault_holds", all_out, 1);
    Clear = 1'b1;
    @(negedge Clock);
    check("tmo_clear", all_out, 0);
    Clear = 1'b0;
    mem_ready = 1'b1;

    // Illegal opcode 11111
    ir = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
    Run = 1'b1;
    wait_t0("ill_t0");
    rr_seen = |{Rin, Rout};
    repeat (3) begin
      @(negedge Clock);
      rr_seen |= |{Rin, Rout};
    end
    check("ill_t3_quiet", all_out, 0);
    @(negedge Clock);
    check("ill_fault_at_t3_edge", Illegal, 1);
    repeat (5) begin
      @(negedge Clock);
      rr_seen |= |{Rin, Rout};
    end
    check("ill_fault_sticky", all_out, 1);
    check("ill_no_reg_select", rr_seen, 0);
    Run = 1'b0;
    Clear = 1'b1;
    @(negedge Clock);
    check("ill_clear", Illegal, 0);
    Clear = 1'b0;
    exp_cnt = '0;

    // Five back-to-back NOTs, retired count wraps at 2 bits
    ir = {OP_NOT, 4'd1, 4'd2, 4'd0, 15'd0};
    for (int k = 0; k < 5; k++) push(16'h0002, 1'b0, 6);
    Run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_t0("b2b_t0");
      t0s[k] = cyc;
      if (k == 4) Run = 1'b0;
    end
    for (int k = 1; k < 5; k++) check("b2b_gap", t0s[k] - t0s[k-1], 6);
    repeat (8) @(negedge Clock);
    check("b2b_final_retired", retired, 1);
    check("b2b_final_idle", all_out, 0);
    check("queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
